ldr_mem_access_unit: RTL and testbench

- Memory-stage producer for the load-writeback path.
- Accepts a decoded LDR/STR (word or byte), issues one request to data memory over a req/ack handshake, and stalls the pipeline while the access is outstanding.
- Returns aligned, zero-extended load data plus a one-cycle valid pulse that the writeback stage turns into its register-file write enable.
- Sits between execute (address/store data) and the LDR writeback unit.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ldr_byte_lane.sv | 36 +++
 rtl/ldr_mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_ldr_mem_access_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-stage load/store path.
//   mem_state_t : access FSM states (IDLE / BUSY / DONE)
//   NUM_LANES, VEC_W, WORD_W, OFF_W : byte-lane geometry of a data word
//   BE_WORD, BE_BYTE0 : byte-enable patterns for word and byte-0 accesses
package cpu_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int WORD_W    = NUM_LANES * VEC_W;
  localparam int OFF_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [NUM_LANES-1:0] BE_WORD  = 4'hF;
  localparam logic [NUM_LANES-1:0] BE_BYTE0 = 4'h1;

endpackage

// File: rtl/ldr_byte_lane.sv
// Byte-lane steering shared by the request and load-return paths, so the
// byte a store writes and the byte a load extracts always agree.
//   byte_op    : byte access (else full word)
//   off        : byte offset within the word (addr[1:0])
//   store_data : register value to store
//   rdata      : word returned by memory
//   be         : byte enables for the request
//   wdata      : write data (byte accesses replicate the low byte to all lanes)
//   load_data  : word load or zero-extended selected byte
module ldr_byte_lane
  import cpu_pkg::*;
(
  input  logic                 byte_op,
  input  logic [OFF_W-1:0]     off,
  input  logic [WORD_W-1:0]    store_data,
  input  logic [WORD_W-1:0]    rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    load_data
);

  logic [NUM_LANES-1:0][VEC_W-1:0] wd_lanes;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;

  assign rd_lanes = rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Replicating the byte means memory picks it up from whichever lane is enabled.
    assign wd_lanes[i] = byte_op ? store_data[VEC_W-1:0] : store_data[i*VEC_W +: VEC_W];
  end

  assign wdata     = wd_lanes;
  assign be        = byte_op ? (BE_BYTE0 << off) : BE_WORD;
  assign load_data = byte_op ? {{(WORD_W-VEC_W){1'b0}}, rd_lanes[off]} : rdata;

endmodule

// File: rtl/ldr_mem_access_unit.sv
// Memory-stage access unit: takes one decoded LDR/STR(B), issues a single
// req/ack transaction to data memory, stalls upstream while it is
// outstanding, and returns aligned load data with a one-cycle ldr_valid.
//   clk, rst_n      : clock; rst_n is a synchronous active-HIGH reset
//   valid_in, is_load, is_store, byte_op, addr, store_data, flush : op from execute
//   mem_req/we/addr/be/wdata, mem_ack, mem_rdata : data memory handshake
//   stall           : hold upstream (combinational)
//   ldr_valid, ldr_data : load result to writeback
//   mem_err         : one-cycle pulse when a request times out
module ldr_mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 byte_op,
  input  logic [WORD_W-1:0]    addr,
  input  logic [WORD_W-1:0]    store_data,
  input  logic                 flush,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_W-1:0]    mem_addr,
  output logic [NUM_LANES-1:0] mem_be,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic                 stall,
  output logic                 ldr_valid,
  output logic [WORD_W-1:0]    ldr_data,
  output logic                 mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  mem_state_t state, state_nxt;

  logic             accept, busy, timeout;
  logic [7:0]       wait_cnt;
  logic             ld_q, byte_q, squash_q;
  logic [OFF_W-1:0] off_q;

  logic                 lane_byte;
  logic [OFF_W-1:0]     lane_off;
  logic [NUM_LANES-1:0] lane_be;
  logic [WORD_W-1:0]    lane_wdata, lane_load;

  assign accept  = valid_in & (is_load ^ is_store) & ~flush;
  assign busy    = (state == BUSY);
  // Ack in the same cycle wins over the timeout.
  assign timeout = busy & ~mem_ack & (wait_cnt == WAIT_LAST);

  // Request fields are only built outside BUSY and load bytes only extracted
  // in BUSY, so one lane block serves both by switching its controls.
  assign lane_byte = busy ? byte_q : byte_op;
  assign lane_off  = busy ? off_q  : addr[OFF_W-1:0];

  ldr_byte_lane u_lane (
    .byte_op    (lane_byte),
    .off        (lane_off),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE, DONE: begin
        stall     = accept;
        state_nxt = accept ? BUSY : IDLE;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack)      state_nxt = DONE;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ldr_valid <= 1'b0;
      ldr_data  <= '0;
      mem_err   <= 1'b0;
      wait_cnt  <= '0;
      ld_q      <= 1'b0;
      byte_q    <= 1'b0;
      off_q     <= '0;
      squash_q  <= 1'b0;
    end else begin
      ldr_valid <= 1'b0;
      mem_err   <= 1'b0;
      if (!busy && accept) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {addr[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_be    <= lane_be;
        mem_wdata <= lane_wdata;
        ld_q      <= is_load;
        byte_q    <= byte_op;
        off_q     <= addr[OFF_W-1:0];
        squash_q  <= 1'b0;
        wait_cnt  <= '0;
      end else if (busy) begin
        // A squashed request still has to complete; only its result is dropped.
        if (flush) squash_q <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (ld_q && !squash_q && !flush) begin
            ldr_valid <= 1'b1;
            ldr_data  <= lane_load;
          end
        end else if (timeout) begin
          mem_req <= 1'b0;
          mem_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldr_mem_access_unit.sv
module tb_ldr_mem_access_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, is_load, is_store, byte_op, flush;
  logic [31:0] addr, store_data, mem_rdata;
  logic        mem_req, mem_we, mem_ack, stall, ldr_valid, mem_err;
  logic [31:0] mem_addr, mem_wdata, ldr_data;
  logic [3:0]  mem_be;

  int          checks = 0;
  int          errors = 0;

  // Transaction-level expectations for the cycle after an op finishes.
  logic [31:0] model_data;
  bit          pend_valid, pend_err, post_rst;

  ldr_mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .byte_op(byte_op), .addr(addr), .store_data(store_data),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .ldr_valid(ldr_valid), .ldr_data(ldr_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_be(input bit b, input logic [31:0] a);
    return b ? (32'd1 << (a % 4)) : 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input bit b, input logic [31:0] sd);
    return b ? (sd & 32'hFF) * 32'h01010101 : sd;
  endfunction

  function automatic logic [31:0] exp_load(input bit b, input logic [31:0] a, input logic [31:0] rd);
    return b ? (rd >> (8 * (a % 4))) & 32'hFF : rd;
  endfunction

  // Checks what the previous op (or reset) should have left behind.
  task automatic check_post();
    chk("ldr_valid", ldr_valid, pend_valid);
    chk("ldr_data", ldr_data, model_data);
    chk("mem_err", mem_err, pend_err);
    chk("mem_req_low", mem_req, 0);
    if (post_rst) begin
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_we", mem_we, 0);
    end
    pend_valid = 0;
    pend_err   = 0;
    post_rst   = 0;
  endtask

  // One cycle that must not accept anything.
  task automatic idle_cycle(input bit v, input bit ld, input bit st, input bit fl, input bit ack);
    @(negedge clk);
    rst_n = 0; valid_in = v; is_load = ld; is_store = st; flush = fl;
    byte_op = 1'($urandom); addr = $urandom; store_data = $urandom;
    mem_ack = ack; mem_rdata = $urandom;
    #1;
    check_post();
    chk("stall_idle", stall, 0);
    @(posedge clk);
  endtask

  // ack_k / flush_k / rst_k: BUSY cycle (1-based) of the event, 0 = never.
  task automatic issue(input bit ld, input bit b, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int ack_k, input int flush_k, input int rst_k);
    bit squashed = 0;
    @(negedge clk);
    rst_n = 0; valid_in = 1; is_load = ld; is_store = !ld; byte_op = b;
    addr = a; store_data = sd; flush = 0; mem_ack = 0; mem_rdata = $urandom;
    #1;
    check_post();
    chk("stall_accept", stall, 1);
    @(posedge clk);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge clk);
      valid_in = 0; addr = $urandom; store_data = $urandom; byte_op = 1'($urandom);
      flush = (k == flush_k); mem_ack = (k == ack_k); rst_n = (k == rst_k);
      mem_rdata = (k == ack_k) ? rd : $urandom;
      #1;
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, !ld);
      chk("mem_addr", mem_addr, a & ~32'd3);
      chk("mem_be", mem_be, exp_be(b, a));
      chk("mem_wdata", mem_wdata, exp_wdata(b, sd));
      chk("stall_busy", stall, 1);
      chk("ldr_valid_busy", ldr_valid, 0);
      chk("mem_err_busy", mem_err, 0);
      if (k == flush_k) squashed = 1;
      @(posedge clk);
      if (k == rst_k) begin
        post_rst = 1; model_data = 0;
        return;
      end
      if (k == ack_k) begin
        if (ld && !squashed) begin
          pend_valid = 1;
          model_data = exp_load(b, a, rd);
        end
        return;
      end
    end
    pend_err = 1;
  endtask

  initial begin
    rst_n = 1; valid_in = 0; is_load = 0; is_store = 0; byte_op = 0; flush = 0;
    addr = 0; store_data = 0; mem_ack = 0; mem_rdata = 0;
    model_data = 0; pend_valid = 0; pend_err = 0; post_rst = 1;
    repeat (2) @(posedge clk);

    // Reset state, then ops that must not be accepted.
    idle_cycle(0, 0, 0, 0, 0);
    idle_cycle(1, 1, 1, 0, 0);
    idle_cycle(1, 1, 0, 1, 0);
    idle_cycle(0, 0, 0, 0, 1);

    // 1: word LDR, ack two cycles after the request rises.
    issue(1, 0, 32'h1004, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    idle_cycle(0, 0, 0, 0, 0);
    // 2: LDRB top byte, zero-wait memory.
    issue(1, 1, 32'h2003, 32'h0, 32'hAABBCCDD, 1, 0, 0);
    idle_cycle(0, 0, 0, 0, 0);
    // 3: STRB lane 1.
    issue(0, 1, 32'h3001, 32'h12345678, 32'hFFFFFFFF, 2, 0, 0);
    idle_cycle(0, 0, 0, 0, 0);
    // 4: LDR squashed while busy; previous ldr_data must survive.
    issue(1, 0, 32'h4000, 32'h0, 32'h55, 3, 1, 0);
    idle_cycle(0, 0, 0, 0, 0);
    // 5: no ack -> timeout, then a late ack that must be ignored.
    issue(1, 0, 32'h5000, 32'h0, 32'h1, 0, 0, 0);
    idle_cycle(0, 0, 0, 0, 1);
    idle_cycle(0, 0, 0, 0, 0);
    // Ack on the last allowed cycle beats the timeout.
    issue(1, 1, 32'h5002, 32'h0, 32'h00CC0000, MAX_WAIT, 0, 0);
    idle_cycle(0, 0, 0, 0, 0);
    // 6: reset mid-access, late ack ignored, then back-to-back loads.
    issue(1, 0, 32'h6000, 32'h0, 32'h77, 0, 0, 2);
    idle_cycle(0, 0, 0, 0, 1);
    issue(1, 0, 32'h6004, 32'h0, 32'hCAFEF00D, 1, 0, 0);
    issue(1, 1, 32'h6009, 32'h0, 32'h0000AB00, 2, 0, 0);
    idle_cycle(0, 0, 0, 0, 0);

    // Randomized ops against the transaction model.
    for (int i = 0; i < 60; i++) begin
      int ack_k, fl_k;
      ack_k = $urandom_range(0, MAX_WAIT);
      fl_k  = ($urandom % 4 == 0) ? $urandom_range(1, MAX_WAIT) : 0;
      issue(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, ack_k, fl_k, 0);
      case ($urandom % 4)
        0: idle_cycle(0, 0, 0, 0, 1'($urandom));
        1: idle_cycle(1, 1, 1, 0, 0);
        2: idle_cycle(1, 1, 0, 1, 0);
        default: ;
      endcase
    end
    idle_cycle(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
